// File: rtl/rsa_decoder_core.sv
// RSA decryption core: data_out = data_in^d mod n using a digit-serial
// Montgomery multiplier (radix 2^logr) and a left-to-right square-and-multiply scan.
// Optional feature: define RSA_DECODER_BUSY_EN to add the registered 'busy' output.
module rsa_decoder_core #(
  parameter int unsigned n      = 3551,
  parameter int unsigned n_bit  = 12,
  parameter int unsigned logr   = 3,
  parameter int unsigned p      = 1,
  parameter int unsigned Rmodn  = 545,
  parameter int unsigned R2modn = 2292,
  parameter int unsigned d      = 1373
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [n_bit-1:0] data_in,
  output logic [n_bit-1:0] data_out,
  output logic             done
`ifdef RSA_DECODER_BUSY_EN
  ,
  output logic             busy
`endif
);

  localparam int unsigned T_W    = n_bit + logr + 2;
  localparam int unsigned DIGITS = n_bit / logr;
  localparam int unsigned K      = DIGITS + 1;
  localparam int unsigned CNT_W  = $clog2(K);
  localparam int unsigned BIT_W  = $clog2(n_bit);
  localparam logic [T_W-1:0]   N_T    = T_W'(n);
  localparam logic [n_bit-1:0] D_BITS = n_bit'(d);

  typedef enum logic [2:0] {
    S_IDLE, S_TOMONT, S_SQR, S_MUL, S_FROMMONT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               start_low_q, start_low_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [n_bit-1:0]   c_q, c_d;
  logic [n_bit-1:0]   xm_q, xm_d;
  logic [n_bit-1:0]   acc_q, acc_d;
  logic [T_W-1:0]     t_q, t_d;
  logic [n_bit-1:0]   data_out_q, data_out_d;
  logic               done_q, done_d;

  logic [n_bit-1:0]   a_src, b_op, mm_res;
  logic [logr-1:0]    a_digit, q_dig;
  logic [T_W-1:0]     t_sum, t_step;
  logic               mm_last;

  // Montgomery operand selection for the current FSM state
  always_comb begin
    a_src = acc_q;
    b_op  = acc_q;
    case (state_q)
      S_TOMONT:   begin a_src = c_q; b_op = n_bit'(R2modn); end
      S_MUL:      b_op = xm_q;
      S_FROMMONT: b_op = n_bit'(1);
      default:    ;
    endcase
  end

  // One Montgomery digit step plus the final conditional subtraction
  always_comb begin
    a_digit = logr'(a_src >> (32'(cnt_q) * logr));
    t_sum   = t_q + T_W'(a_digit) * T_W'(b_op);
    q_dig   = logr'(t_sum[logr-1:0] * logr'(p));
    t_step  = (t_sum + T_W'(q_dig) * N_T) >> logr;
    mm_res  = (t_q >= N_T) ? n_bit'(t_q - N_T) : n_bit'(t_q);
    mm_last = (cnt_q == CNT_W'(K - 1));
  end

  // Next-state and datapath control; DONE spends one cycle raising done, then returns to IDLE
  always_comb begin
    state_d     = state_q;
    start_low_d = ~start;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    c_d         = c_q;
    xm_d        = xm_q;
    acc_d       = acc_q;
    t_d         = t_q;
    data_out_d  = data_out_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && start_low_q) begin
          state_d = S_TOMONT;
          c_d     = data_in;
          acc_d   = n_bit'(Rmodn);
          t_d     = '0;
          cnt_d   = '0;
          bit_d   = BIT_W'(n_bit - 1);
        end
      end
      S_TOMONT, S_SQR, S_MUL, S_FROMMONT: begin
        if (!mm_last) begin
          t_d   = t_step;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          t_d   = '0;
          cnt_d = '0;
          case (state_q)
            S_TOMONT: begin
              xm_d    = mm_res;
              state_d = S_SQR;
            end
            S_SQR: begin
              acc_d = mm_res;
              if (D_BITS[bit_q])      state_d = S_MUL;
              else if (bit_q == '0)   state_d = S_FROMMONT;
              else begin
                bit_d   = bit_q - BIT_W'(1);
                state_d = S_SQR;
              end
            end
            S_MUL: begin
              acc_d = mm_res;
              if (bit_q == '0) state_d = S_FROMMONT;
              else begin
                bit_d   = bit_q - BIT_W'(1);
                state_d = S_SQR;
              end
            end
            default: begin
              acc_d   = mm_res;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_DONE: begin
        if (!done_q) begin
          done_d     = 1'b1;
          data_out_d = acc_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      start_low_q <= 1'b0;
      cnt_q       <= '0;
      bit_q       <= '0;
      c_q         <= '0;
      xm_q        <= '0;
      acc_q       <= '0;
      t_q         <= '0;
      data_out_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_low_q <= start_low_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      c_q         <= c_d;
      xm_q        <= xm_d;
      acc_q       <= acc_d;
      t_q         <= t_d;
      data_out_q  <= data_out_d;
      done_q      <= done_d;
    end
  end

  assign data_out = data_out_q;
  assign done     = done_q;

`ifdef RSA_DECODER_BUSY_EN
  logic busy_q;

  // busy follows the registered FSM activity (high whenever not IDLE)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= 1'b0;
    else        busy_q <= (state_d != S_IDLE);
  end

  assign busy = busy_q;
`endif

endmodule

// File: tb/tb_rsa_decoder_core.sv
// Scoreboard bench for rsa_decoder_core: the driver pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_rsa_decoder_core;

  localparam int unsigned NB    = 12;
  localparam longint      N_MOD = 3551;
  localparam longint      D_EXP = 1373;
  localparam int          LAT   = 107;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [NB-1:0] data_in;
  logic [NB-1:0] data_out;
  logic          done;
`ifdef RSA_DECODER_BUSY_EN
  logic          busy;
`endif

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int busy_cyc = 0;

  logic [NB-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [NB-1:0] in_q[$];

  logic [NB-1:0] mon_exp;
  logic [NB-1:0] mon_in;
  int            mon_cyc;

  rsa_decoder_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data_in  (data_in),
    .data_out (data_out),
    .done     (done)
`ifdef RSA_DECODER_BUSY_EN
    ,
    .busy     (busy)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Plain square-and-multiply reference, independent of the Montgomery datapath
  function automatic longint modpow(input longint b, input longint e, input longint m);
    longint r = 1;
    longint bb = b % m;
    longint ee = e;
    while (ee > 0) begin
      if (ee[0]) r = (r * bb) % m;
      bb = (bb * bb) % m;
      ee = ee >> 1;
    end
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: compare every done pulse against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
`ifdef RSA_DECODER_BUSY_EN
      if (busy) busy_cyc++;
`endif
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("done with no launch pending", exp_q.size(), 1);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_cyc = exp_cyc_q.pop_front();
          mon_in  = in_q.pop_front();
          check("data_out", data_out, mon_exp);
          check("done latency", cyc, mon_cyc);
          check("data_out^5 mod n", modpow(longint'(data_out), 5, N_MOD), mon_in);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_done(input int prev);
    int k = 0;
    while (done_cnt == prev && k < 300) begin
      step();
      k++;
    end
    if (done_cnt == prev) check("done timeout", done_cnt, prev + 1);
  endtask

  // One decryption; optional start drop and re-rise mid-run, start held high after done
  task automatic run(input logic [NB-1:0] c, input logic [NB-1:0] m, input bit toggle);
    int prev;
    start = 1'b0;
    step();
    data_in = c;
    start   = 1'b1;
    exp_q.push_back(m);
    exp_cyc_q.push_back(cyc + LAT);
    in_q.push_back(c);
    prev     = done_cnt;
    busy_cyc = 0;
    step();
    data_in = NB'($urandom_range(0, 4095));
    if (toggle) begin
      repeat (30) step();
      start = 1'b0;
      repeat (5) step();
      start = 1'b1;
      data_in = NB'($urandom_range(0, 4095));
    end
    wait_done(prev);
`ifdef RSA_DECODER_BUSY_EN
    check("busy cycles", busy_cyc, LAT);
`endif
    repeat (20) step();
    check("done pulses per run", done_cnt, prev + 1);
    start = 1'b0;
  endtask

  initial begin
    int prev;
    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    repeat (3) step();
    check("reset data_out", data_out, 0);
    check("reset done", done, 0);
    rst_n = 1'b1;
    step();

    run(12'd32,   12'd2,    1'b0);
    run(12'd243,  12'd3,    1'b0);
    run(12'd3550, 12'd3550, 1'b0);
    run(12'd2959, NB'(modpow(2959, D_EXP, N_MOD)), 1'b0);
    run(12'd59,   NB'(modpow(59, D_EXP, N_MOD)),   1'b0);
    run(12'd32,   12'd2,    1'b1);
    run(12'd0,    12'd0,    1'b0);

    // Abort mid-run: immediate clear, no done, no relaunch while start stays high
    step();
    data_in = 12'd243;
    start   = 1'b1;
    repeat (50) step();
    rst_n = 1'b0;
    #1;
    check("abort data_out", data_out, 0);
    check("abort done", done, 0);
    step();
    step();
    rst_n = 1'b1;
    prev  = done_cnt;
    repeat (150) step();
    check("no done after abort", done_cnt, prev);
    start = 1'b0;
    step();

    run(12'd1, 12'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
